// File: rtl/csum_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one checksum inserter; opens a valid-low
// bubble after every CSUM_INTERVAL beats and after tlast so the inserter can emit its checksum.

module csum_arb_lane #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int ID_W   = 6
) (
  input  logic              i_sel,
  input  logic              i_m_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic [ID_W-1:0]   i_id,
  input  logic              i_last,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic [ID_W-1:0]   o_id,
  output logic              o_last,
  output logic              o_valid,
  output logic              o_ready
);
  // Unselected lanes contribute zeros so the top can OR-reduce all lanes.
  assign o_data  = i_sel ? i_data : '0;
  assign o_keep  = i_sel ? i_keep : '0;
  assign o_id    = i_sel ? i_id   : '0;
  assign o_last  = i_sel & i_last;
  assign o_valid = i_sel & i_valid;
  assign o_ready = i_sel & i_m_ready;
endmodule

module csum_stream_arbiter #(
  parameter  int N_SRC         = 4,
  parameter  int DATA_W        = 512,
  parameter  int KEEP_W        = 64,
  parameter  int ID_W          = 6,
  parameter  int CSUM_INTERVAL = 4,
  parameter  int GAP_CYCLES    = 1,
  localparam int GW            = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] s_data,
  input  logic [N_SRC*KEEP_W-1:0] s_keep,
  input  logic [N_SRC*ID_W-1:0]   s_id,
  input  logic [N_SRC-1:0]        s_last,
  input  logic [N_SRC-1:0]        s_valid,
  output logic [N_SRC-1:0]        s_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic [KEEP_W-1:0]       m_keep,
  output logic [ID_W-1:0]         m_id,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [GW-1:0]           grant_idx,
  output logic                    csum_slot
);
  localparam int BCW = (CSUM_INTERVAL > 1) ? $clog2(CSUM_INTERVAL) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PASS, GAP} state_t;

  state_t         r_state, w_state_nxt;
  logic [GW-1:0]  r_grant, w_grant_nxt;
  logic [GW-1:0]  r_rr_ptr, w_rr_nxt;
  logic [BCW-1:0] r_beat_cnt, w_beat_nxt;
  logic [GCW-1:0] r_gap_cnt, w_gap_nxt;
  logic           r_last_seen, w_last_nxt;

  logic [N_SRC-1:0]             w_sel;
  logic [N_SRC-1:0][DATA_W-1:0] w_lane_data;
  logic [N_SRC-1:0][KEEP_W-1:0] w_lane_keep;
  logic [N_SRC-1:0][ID_W-1:0]   w_lane_id;
  logic [N_SRC-1:0]             w_lane_last;
  logic [N_SRC-1:0]             w_lane_vld;
  logic                         w_any;
  logic [GW-1:0]                w_arb_idx;
  logic                         w_beat;

  for (genvar k = 0; k < N_SRC; k++) begin : g_sel
    assign w_sel[k] = (r_state == PASS) && (r_grant == GW'(k));
  end

  csum_arb_lane #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W)) u_lane [N_SRC-1:0] (
    .i_sel    (w_sel),
    .i_m_ready(m_ready),
    .i_data   (s_data),
    .i_keep   (s_keep),
    .i_id     (s_id),
    .i_last   (s_last),
    .i_valid  (s_valid),
    .o_data   (w_lane_data),
    .o_keep   (w_lane_keep),
    .o_id     (w_lane_id),
    .o_last   (w_lane_last),
    .o_valid  (w_lane_vld),
    .o_ready  (s_ready)
  );

  always_comb begin
    m_data = '0;
    m_keep = '0;
    m_id   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      m_data = m_data | w_lane_data[k];
      m_keep = m_keep | w_lane_keep[k];
      m_id   = m_id   | w_lane_id[k];
    end
  end

  assign m_last    = |w_lane_last;
  assign m_valid   = |w_lane_vld;
  assign w_beat    = m_valid & m_ready;
  assign grant_idx = r_grant;
  assign csum_slot = (r_state == GAP);

  // Round-robin search starting at r_rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    int j;
    j         = 0;
    w_any     = 1'b0;
    w_arb_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      j = int'(r_rr_ptr) + i;
      if (j >= N_SRC) j = j - N_SRC;
      if (!w_any && s_valid[j]) begin
        w_any     = 1'b1;
        w_arb_idx = GW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_last_nxt  = r_last_seen;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_arb_idx;
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        if (w_beat) begin
          if (m_last || (r_beat_cnt == BCW'(CSUM_INTERVAL - 1))) begin
            w_state_nxt = GAP;
            w_beat_nxt  = '0;
            w_gap_nxt   = '0;
            w_last_nxt  = m_last;
          end else begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == GCW'(GAP_CYCLES - 1)) begin
          w_gap_nxt = '0;
          if (r_last_seen) begin
            w_rr_nxt    = (r_grant == GW'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
            w_last_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = PASS;
          end
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_last_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_last_seen <= w_last_nxt;
    end
  end
endmodule

// File: tb/tb_csum_stream_arbiter.sv
// Bench for csum_stream_arbiter: two instances (1- and 2-cycle bubbles) share stimulus;
// vector table, directed corner sequences, then random traffic against a packet-level model.

module tb_csum_stream_arbiter;
  localparam int N = 4, DW = 32, KW = 4, IW = 6, CI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*DW-1:0] s_data;
  logic [N*KW-1:0] s_keep;
  logic [N*IW-1:0] s_id;
  logic [N-1:0]    s_last, s_valid;
  logic            m_ready;

  logic [1:0][N-1:0]  sr;
  logic [1:0][DW-1:0] md;
  logic [1:0][KW-1:0] mk;
  logic [1:0][IW-1:0] mi;
  logic [1:0][1:0]    gi;
  logic [1:0]         ml, mv, cs;

  always #5 clk = ~clk;

  csum_stream_arbiter #(.N_SRC(N), .DATA_W(DW), .KEEP_W(KW), .ID_W(IW),
                        .CSUM_INTERVAL(CI), .GAP_CYCLES(1)) u_dut0 (
    .clock(clk), .reset(rst), .s_data(s_data), .s_keep(s_keep), .s_id(s_id),
    .s_last(s_last), .s_valid(s_valid), .s_ready(sr[0]), .m_data(md[0]), .m_keep(mk[0]),
    .m_id(mi[0]), .m_last(ml[0]), .m_valid(mv[0]), .m_ready(m_ready),
    .grant_idx(gi[0]), .csum_slot(cs[0]));

  csum_stream_arbiter #(.N_SRC(N), .DATA_W(DW), .KEEP_W(KW), .ID_W(IW),
                        .CSUM_INTERVAL(CI), .GAP_CYCLES(2)) u_dut1 (
    .clock(clk), .reset(rst), .s_data(s_data), .s_keep(s_keep), .s_id(s_id),
    .s_last(s_last), .s_valid(s_valid), .s_ready(sr[1]), .m_data(md[1]), .m_keep(mk[1]),
    .m_id(mi[1]), .m_last(ml[1]), .m_valid(mv[1]), .m_ready(m_ready),
    .grant_idx(gi[1]), .csum_slot(cs[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int k);
    return s_data[k*DW +: DW];
  endfunction
  function automatic logic [KW-1:0] kep(input int k);
    return s_keep[k*KW +: KW];
  endfunction
  function automatic logic [IW-1:0] idv(input int k);
    return s_id[k*IW +: IW];
  endfunction

  task automatic set_const_data();
    for (int k = 0; k < N; k++) begin
      s_data[k*DW +: DW] = 32'hD000_0000 | DW'(k);
      s_keep[k*KW +: KW] = KW'(k + 1);
      s_id[k*IW +: IW]   = IW'(16 + k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Packet-level reference: which source owns the stream, beats since the last slot,
  // bubble cycles still owed, and where the next search starts.
  int busy[2], src[2], cnt[2], gl[2], endp[2], ptr[2], gap_len[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; src[d] = 0; cnt[d] = 0; gl[d] = 0; endp[d] = 0; ptr[d] = 0;
    end
  endtask

  task automatic model_check(input int d, input int cyc);
    bit pass;
    logic [N-1:0] esr;
    pass = (busy[d] != 0) && (gl[d] == 0);
    esr  = '0;
    if (pass && m_ready) esr[src[d]] = 1'b1;
    chk($sformatf("rnd.d%0d.c%0d.m_valid", d, cyc), mv[d], pass ? s_valid[src[d]] : 1'b0);
    chk($sformatf("rnd.d%0d.c%0d.s_ready", d, cyc), sr[d], esr);
    chk($sformatf("rnd.d%0d.c%0d.m_data", d, cyc), md[d], pass ? dat(src[d]) : '0);
    chk($sformatf("rnd.d%0d.c%0d.m_keep", d, cyc), mk[d], pass ? kep(src[d]) : '0);
    chk($sformatf("rnd.d%0d.c%0d.m_id", d, cyc), mi[d], pass ? idv(src[d]) : '0);
    chk($sformatf("rnd.d%0d.c%0d.m_last", d, cyc), ml[d], pass ? s_last[src[d]] : 1'b0);
    chk($sformatf("rnd.d%0d.c%0d.csum_slot", d, cyc), cs[d], gl[d] > 0);
    chk($sformatf("rnd.d%0d.c%0d.grant", d, cyc), gi[d], src[d]);
  endtask

  task automatic model_step(input int d);
    bit found;
    int k;
    if (gl[d] > 0) begin
      gl[d]--;
      if (gl[d] == 0 && endp[d] != 0) begin
        busy[d] = 0;
        ptr[d]  = (src[d] + 1) % N;
      end
    end else if (busy[d] != 0) begin
      if (s_valid[src[d]] && m_ready) begin
        cnt[d]++;
        if (s_last[src[d]] || cnt[d] == CI) begin
          gl[d]   = gap_len[d];
          endp[d] = s_last[src[d]];
          cnt[d]  = 0;
        end
      end
    end else begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        k = (ptr[d] + i) % N;
        if (!found && s_valid[k]) begin
          found   = 1'b1;
          busy[d] = 1;
          src[d]  = k;
        end
      end
    end
  endtask

  typedef struct {
    int         d;
    logic [3:0] v, l;
    logic       rdy;
    logic       e_mv;
    logic [3:0] e_sr;
    logic       e_ml, e_cs;
    logic [1:0] e_gi;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int got;
    bit oh_ok;
    logic [1:0] rec[4];

    gap_len[0] = 1; gap_len[1] = 2;
    // 3-beat src0 packet on the 1-cycle-bubble instance
    tbl[0]  = '{0, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{0, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    // 4-beat src1 packet, interval and tlast coincide, 2-cycle bubble
    tbl[6]  = '{1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd1};
    tbl[8]  = '{1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd1};
    tbl[9]  = '{1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd1};
    tbl[10] = '{1, 4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1};
    tbl[11] = '{1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1};
    tbl[12] = '{1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1};
    tbl[13] = '{1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1};

    s_valid = '0; s_last = '0; m_ready = 1'b0;
    set_const_data();
    s_valid = 4'b0011; m_ready = 1'b1;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst.d%0d.m_valid", d), mv[d], 1'b0);
      chk($sformatf("rst.d%0d.s_ready", d), sr[d], '0);
      chk($sformatf("rst.d%0d.m_data", d), md[d], '0);
      chk($sformatf("rst.d%0d.csum_slot", d), cs[d], 1'b0);
      chk($sformatf("rst.d%0d.grant", d), gi[d], '0);
    end
    do_reset();

    for (int i = 0; i < 14; i++) begin
      int d;
      if (i == 6) do_reset();
      @(negedge clk);
      s_valid = tbl[i].v; s_last = tbl[i].l; m_ready = tbl[i].rdy;
      #1;
      d = tbl[i].d;
      chk($sformatf("tbl%0d.m_valid", i), mv[d], tbl[i].e_mv);
      chk($sformatf("tbl%0d.s_ready", i), sr[d], tbl[i].e_sr);
      chk($sformatf("tbl%0d.m_last", i), ml[d], tbl[i].e_ml);
      chk($sformatf("tbl%0d.csum_slot", i), cs[d], tbl[i].e_cs);
      chk($sformatf("tbl%0d.grant", i), gi[d], tbl[i].e_gi);
      chk($sformatf("tbl%0d.m_data", i), md[d], tbl[i].e_mv ? dat(int'(tbl[i].e_gi)) : '0);
      chk($sformatf("tbl%0d.m_id", i), mi[d], tbl[i].e_mv ? idv(int'(tbl[i].e_gi)) : '0);
    end

    // Backpressure after beat 2 must not move the slot boundary.
    do_reset();
    @(negedge clk);
    s_valid = 4'b0100; m_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      s_data[2*DW +: DW] = DW'(100 + b);
      if (b == 3) begin
        m_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk($sformatf("bp.stall%0d.s_ready", s), sr[0], '0);
          chk($sformatf("bp.stall%0d.m_valid", s), mv[0], 1'b1);
          chk($sformatf("bp.stall%0d.m_data", s), md[0], DW'(103));
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
      #1;
      chk($sformatf("bp.beat%0d.s_ready", b), sr[0], 4'b0100);
      chk($sformatf("bp.beat%0d.m_data", b), md[0], DW'(100 + b));
      chk($sformatf("bp.beat%0d.csum_slot", b), cs[0], 1'b0);
    end
    @(negedge clk);
    #1;
    chk("bp.gap.csum_slot", cs[0], 1'b1);
    chk("bp.gap.m_valid", mv[0], 1'b0);

    // Asynchronous reset in the middle of a packet.
    set_const_data();
    do_reset();
    @(negedge clk);
    s_valid = 4'b0010; m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar.beat2.m_valid", mv[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("ar.in_rst.m_valid", mv[0], 1'b0);
    chk("ar.in_rst.s_ready", sr[0], '0);
    chk("ar.in_rst.grant", gi[0], '0);
    #1 rst = 1'b0;
    s_valid = 4'b0011;
    @(negedge clk);
    #1;
    chk("ar.after.grant", gi[0], 2'd0);
    chk("ar.after.s_ready", sr[0], 4'b0001);

    // Two continuously valid sources alternate packet by packet.
    do_reset();
    s_valid = 4'b0011; s_last = 4'b0011; m_ready = 1'b1;
    got = 0; oh_ok = 1'b1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      #1;
      if ($countones(sr[0]) > 1) oh_ok = 1'b0;
      if (mv[0] && m_ready) begin
        rec[got] = gi[0];
        got++;
      end
    end
    chk("rr.packets_seen", got, 4);
    chk("rr.onehot0", oh_ok, 1'b1);
    for (int i = 0; i < got; i++)
      chk($sformatf("rr.pkt%0d.grant", i), rec[i], 2'(i % 2));

    // Random traffic against the packet-level model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000 && bad < 50; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        s_valid[k]         = ($urandom_range(0, 9) < 7);
        s_last[k]          = ($urandom_range(0, 9) < 2);
        s_data[k*DW +: DW] = $urandom();
        s_keep[k*KW +: KW] = KW'($urandom());
        s_id[k*IW +: IW]   = IW'($urandom());
      end
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int d = 0; d < 2; d++) model_check(d, c);
      for (int d = 0; d < 2; d++) model_step(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
